// File: rtl/iteration_controller_pkg.sv
// Shared constants and FSM state encoding for the iteration controller,
// so that monitors and checkers decode the controller state the same way.
package iteration_controller_pkg;

  localparam int DEF_CORE_NUM        = 4;
  localparam int DEF_ITERATION_WIDTH = 8;
  localparam int DEF_WAIT_END_DELAY  = 3;
  localparam int DEF_RST_CYCLES      = 8;
  localparam int DEF_ACT_WIDTH       = 32;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    RESET_CORES = 3'd1,
    LAUNCH      = 3'd2,
    RUN         = 3'd3,
    ADVANCE     = 3'd4,
    DONE        = 3'd5
  } state_e;

  function automatic logic state_holds_cores(input state_e s);
    return (s == IDLE) || (s == RESET_CORES) || (s == DONE);
  endfunction

  function automatic logic state_is_busy(input state_e s);
    return (s == RESET_CORES) || (s == LAUNCH) || (s == RUN) || (s == ADVANCE);
  endfunction

endpackage

// File: rtl/iteration_controller_popcount_tree.sv
// Combinational population count built as a balanced binary adder tree.
// Result width is $clog2(IN_WIDTH)+1, enough to hold IN_WIDTH itself.
module popcount_tree #(
  parameter int IN_WIDTH = 4
) (
  input  logic [IN_WIDTH-1:0]      bits_i,
  output logic [$clog2(IN_WIDTH):0] count_o
);

  localparam int OUT_WIDTH = $clog2(IN_WIDTH) + 1;

  generate
    if (IN_WIDTH == 1) begin : g_leaf
      assign count_o = bits_i;
    end else begin : g_node
      localparam int LO_W  = IN_WIDTH / 2;
      localparam int HI_W  = IN_WIDTH - LO_W;
      localparam int LO_OW = $clog2(LO_W) + 1;
      localparam int HI_OW = $clog2(HI_W) + 1;

      logic [LO_OW-1:0] lo_ct;
      logic [HI_OW-1:0] hi_ct;

      popcount_tree #(.IN_WIDTH(LO_W)) u_lo (
        .bits_i (bits_i[LO_W-1:0]),
        .count_o(lo_ct)
      );

      popcount_tree #(.IN_WIDTH(HI_W)) u_hi (
        .bits_i (bits_i[IN_WIDTH-1:LO_W]),
        .count_o(hi_ct)
      );

      assign count_o = OUT_WIDTH'(lo_ct) + OUT_WIDTH'(hi_ct);
    end
  endgenerate

endmodule

// File: rtl/iteration_controller.sv
// Global iteration sequencer: resets the core pipelines, launches iterations,
// waits for a core-wide end barrier and stops on convergence or iteration limit.
module iteration_controller
  import iteration_controller_pkg::*;
#(
  parameter int CORE_NUM        = DEF_CORE_NUM,
  parameter int ITERATION_WIDTH = DEF_ITERATION_WIDTH,
  parameter int WAIT_END_DELAY  = DEF_WAIT_END_DELAY,
  parameter int RST_CYCLES      = DEF_RST_CYCLES,
  parameter int ACT_WIDTH       = DEF_ACT_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [ITERATION_WIDTH-1:0] max_iteration,
  input  logic [CORE_NUM-1:0]        sched_iteration_end,
  input  logic [CORE_NUM-1:0]        sched_iteration_end_valid,
  input  logic [CORE_NUM-1:0]        sched_update_v_valid,
  output logic [CORE_NUM-1:0]        core_rst,
  output logic                       iteration_start,
  output logic [ITERATION_WIDTH-1:0] iteration_id,
  output logic [ACT_WIDTH-1:0]       activity_ct,
  output logic                       busy,
  output logic                       done,
  output logic                       converged,
  output state_e                     dbg_state
);

  localparam int PC_W  = $clog2(CORE_NUM) + 1;
  localparam int END_W = $clog2(WAIT_END_DELAY + 1);
  localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int SUM_W = ACT_WIDTH + 1;

  state_e                     state_q, state_d;
  logic [RST_W-1:0]           rst_ct_q, rst_ct_d;
  logic [END_W-1:0]           end_ct_q, end_ct_d;
  logic [ITERATION_WIDTH-1:0] max_iter_q, max_iter_d;
  logic [ITERATION_WIDTH-1:0] iter_q, iter_d;
  logic [ACT_WIDTH-1:0]       act_q, act_d;
  logic                       conv_q, conv_d;
  logic [CORE_NUM-1:0]        core_rst_q, core_rst_d;
  logic                       iter_start_q, iter_start_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;

  logic                       all_end;
  logic                       any_upd;
  logic [PC_W-1:0]            upd_count;
  logic [SUM_W-1:0]           act_sum;
  logic [ACT_WIDTH-1:0]       act_sat;
  logic [ITERATION_WIDTH-1:0] iter_inc;

  popcount_tree #(.IN_WIDTH(CORE_NUM)) u_popcount (
    .bits_i (sched_update_v_valid),
    .count_o(upd_count)
  );

  assign all_end  = &(sched_iteration_end & sched_iteration_end_valid);
  assign any_upd  = |sched_update_v_valid;
  assign act_sum  = {1'b0, act_q} + SUM_W'(upd_count);
  assign act_sat  = act_sum[ACT_WIDTH] ? '1 : act_sum[ACT_WIDTH-1:0];
  assign iter_inc = iter_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    rst_ct_d     = rst_ct_q;
    end_ct_d     = end_ct_q;
    max_iter_d   = max_iter_q;
    iter_d       = iter_q;
    act_d        = act_q;
    conv_d       = conv_q;
    core_rst_d   = core_rst_q;
    iter_start_d = 1'b0;
    busy_d       = busy_q;
    done_d       = done_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = RESET_CORES;
          max_iter_d = max_iteration;
          iter_d     = '0;
          conv_d     = 1'b0;
          rst_ct_d   = '0;
        end
      end
      RESET_CORES: begin
        if (rst_ct_q == RST_W'(RST_CYCLES - 1)) begin
          state_d = LAUNCH;
        end else begin
          rst_ct_d = rst_ct_q + 1'b1;
        end
      end
      LAUNCH: begin
        // The counter restarts here, but updates already arriving count.
        act_d    = ACT_WIDTH'(upd_count);
        end_ct_d = '0;
        state_d  = RUN;
      end
      RUN: begin
        act_d = act_sat;
        // An update in the same cycle as the end flags disqualifies that cycle.
        if (all_end && !any_upd) begin
          end_ct_d = end_ct_q + 1'b1;
          if (end_ct_q == END_W'(WAIT_END_DELAY - 1)) begin
            state_d = ADVANCE;
          end
        end else begin
          end_ct_d = '0;
        end
      end
      ADVANCE: begin
        if (act_q == '0) begin
          state_d = DONE;
          conv_d  = 1'b1;
        end else if ((max_iter_q != '0) && (iter_inc == max_iter_q)) begin
          state_d = DONE;
          conv_d  = 1'b0;
        end else begin
          iter_d  = iter_inc;
          state_d = LAUNCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with state_q.
    core_rst_d   = state_holds_cores(state_d) ? '1 : '0;
    iter_start_d = (state_d == LAUNCH);
    busy_d       = state_is_busy(state_d);
    done_d       = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      rst_ct_q     <= '0;
      end_ct_q     <= '0;
      max_iter_q   <= '0;
      iter_q       <= '0;
      act_q        <= '0;
      conv_q       <= 1'b0;
      core_rst_q   <= '1;
      iter_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rst_ct_q     <= rst_ct_d;
      end_ct_q     <= end_ct_d;
      max_iter_q   <= max_iter_d;
      iter_q       <= iter_d;
      act_q        <= act_d;
      conv_q       <= conv_d;
      core_rst_q   <= core_rst_d;
      iter_start_q <= iter_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign core_rst        = core_rst_q;
  assign iteration_start = iter_start_q;
  assign iteration_id    = iter_q;
  assign activity_ct     = act_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign converged       = conv_q;
  assign dbg_state       = state_q;

endmodule
